multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control sequencer for the 4-bit-opcode CPU core. It replaces single-cycle combinational decode with a FETCH/DECODE/EXEC/MEM/WB state machine and waits on a memory handshake. It adds a memory timeout that halts the core, illegal-opcode flagging, HALT resume, and a retired-instruction counter. It sits between the instruction register, the ALU/regfile datapath and the unified memory port.

## Interface
- `OPC_W`, 4, opcode width; must be ≥4; any nonzero bit above bit 3 makes the opcode illegal
- `MEM_TIMEOUT`, 15, max cycles to wait for `mem_ack`; 0 disables the timeout
- `CNT_W`, 16, width of the retired-instruction counter

- `clk` in 1: the single clock
- `rst_n` in 1: synchronous, active-low reset
- `opcode` in OPC_W: from the IR; stable from DECODE until the instruction completes
- `zero` in 1: ALU zero flag, sampled in EXEC
- `mem_ack` in 1: memory completion, valid in FETCH/MEM
- `run` in 1: resume from HALT
- `mem_req`, `mem_read`, `mem_write` out 1: memory request and direction
- `ir_load`, `pc_inc`, `pc_load`, `branch`, `link_sel` out 1: PC/IR controls
- `reg_write`, `alu_src` out 1: datapath controls
- `alu_op` out 3: 000 ADD, 001 XOR, 010 PASS-B, 011 SUB, 100 AND, 101 MUL
- `halted`, `illegal`, `bus_err` out 1: status
- `state` out 3: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5
- `retired` out CNT_W: completed-instruction count

## Operation
- While `rst_n`=0: state←FETCH, counters←0, all outputs 0.
- FETCH: `mem_req`=`mem_read`=1 until `mem_ack`. On ack: pulse `ir_load` and `pc_inc`, then go to DECODE.
- DECODE: classify the opcode.
  - 0111 HALT → HALT.
  - Illegal (0101, upper bits set, or 1111 without MUL_EN) → pulse `illegal`, go to FETCH; not retired.
  - Otherwise → EXEC.
- EXEC drives `alu_op`/`alu_src`; these are held through MEM/WB.
  - ADD 0000 (000,0), SUB 0001 (011,0), XOR 0011 (001,0), AND 0100 (100,0), MOV 1011 (010,0), MUL 1111 (101,0), LDI 0010 (010,1): go to WB.
  - READ 1010 and STR 1001 (010,1): go to MEM.
  - JMP 0110 (010,1) and JR 1101 (010,0): `pc_load`=1, go to FETCH.
  - BEQZ 1000 / BNE 1110 (011,0): `branch`=`pc_load`=`zero` / `~zero`, go to FETCH.
  - JAL 1100 (010,1): go to WB.
- MEM: `mem_req`=1 with `mem_read` (READ) or `mem_write` (STR) until `mem_ack`. READ then goes to WB; STR goes to FETCH.
- WB: `reg_write`=1 for exactly one cycle, then FETCH. For JAL, `link_sel`=`pc_load`=1 in the same cycle.
- HALT: `halted`=1. `run`=1 → FETCH. `run` is ignored in every other state.
- Timeout: a wait counter clears on entry to FETCH/MEM and increments each cycle without `mem_ack`.
  - When the count reaches MEM_TIMEOUT with no ack: pulse `bus_err`, drop `mem_req`, go to HALT; not retired.
  - An ack in the same cycle as the limit wins.
- `retired` increments on every EXEC/MEM/WB→FETCH transition and on DECODE→HALT. It wraps modulo 2^CNT_W.

## Timing
- Outputs are Moore decodes of `state` and `opcode`. There is no combinational path from `mem_ack`/`run` to outputs, except `zero` to `branch`/`pc_load` in EXEC.
- Zero-wait memory (ack in the first request cycle) gives these latencies:
  - ALU/LDI/MOV/MUL: 4 cycles
  - READ: 5 cycles
  - STR: 4 cycles
  - Jumps and branches: 3 cycles
  - JAL: 4 cycles
- Each wait cycle adds 1 cycle.
- Reset mid-instruction aborts it. No write strobe is issued after the reset edge.
- `illegal` and `bus_err` are single-cycle pulses.

## Configuration
- `MUL_EN` defined: opcode 1111 decodes as MUL (alu_op 101, WB path).
- Undefined: opcode 1111 is illegal (`illegal` pulse, no `reg_write`), and alu_op 101 is never driven.

## Test plan
- ADD with ack in the first cycle → state sequence 0,1,2,4,0; `reg_write` high only in WB; `retired` 0→1.
- READ with `mem_ack` delayed 3 cycles in MEM → `mem_req`/`mem_read` high for 4 cycles; total 8 cycles; `reg_write` one cycle.
- BNE with `zero`=0 → `pc_load`=`branch`=1 in EXEC. BEQZ with `zero`=0 → `pc_load`=0. Both take 3 cycles.
- Fetch with `mem_ack` stuck low, MEM_TIMEOUT=15 → `bus_err` pulse 15 cycles after FETCH entry, then `halted`=1. `run` pulse → FETCH.
- Opcode 0101, then 1111 without MUL_EN → `illegal` pulse each time, no `reg_write`, `retired` unchanged. With MUL_EN, 1111 → alu_op 101.
- HALT instruction → `halted` and `retired`+1. Assert `rst_n`=0 during a READ in MEM → all outputs 0, and FETCH resumes after release.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Unified memory-port handshake between the control sequencer (master) and memory (slave).
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_read;
  logic mem_write;
  logic mem_ack;

  modport master (output mem_req, output mem_read, output mem_write, input mem_ack);
  modport slave  (input mem_req, input mem_read, input mem_write, output mem_ack);
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with memory timeout and retire counter.
// Optional feature: define MUL_EN to decode opcode 1111 as MUL; otherwise 1111 is illegal.
module multicycle_ctrl #(
  parameter int OPC_W       = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_ctrl_if.master    mem,
  input  logic [OPC_W-1:0]     opcode,
  input  logic                 zero,
  input  logic                 run,
  output logic                 ir_load,
  output logic                 pc_inc,
  output logic                 pc_load,
  output logic                 branch,
  output logic                 link_sel,
  output logic                 reg_write,
  output logic                 alu_src,
  output logic [2:0]           alu_op,
  output logic                 halted,
  output logic                 illegal,
  output logic                 bus_err,
  output logic [2:0]           state,
  output logic [CNT_W-1:0]     retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000, OP_SUB  = 4'b0001, OP_LDI  = 4'b0010, OP_XOR  = 4'b0011,
    OP_AND  = 4'b0100, OP_BAD  = 4'b0101, OP_JMP  = 4'b0110, OP_HALT = 4'b0111,
    OP_BEQZ = 4'b1000, OP_STR  = 4'b1001, OP_READ = 4'b1010, OP_MOV  = 4'b1011,
    OP_JAL  = 4'b1100, OP_JR   = 4'b1101, OP_BNE  = 4'b1110, OP_MUL  = 4'b1111
  } op_e;

  localparam int TW    = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int LIM_I = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [TW-1:0] LIMIT = TW'(LIM_I);

  state_e          r_state;
  state_e          w_next;
  logic [TW-1:0]   r_wait;
  logic [CNT_W-1:0] r_retired;
  logic            r_bus_err;

  op_e             w_op;
  logic            w_upper;
  logic            w_is_halt;
  logic            w_is_illegal;
  logic            w_limit;
  logic            w_timeout;
  logic            w_retire;
  logic            w_waiting;
  logic [2:0]      w_alu_op;
  logic            w_alu_src;

  assign w_op      = op_e'(opcode[3:0]);
  assign w_upper   = |(opcode >> 4);
  assign w_is_halt = !w_upper && (w_op == OP_HALT);
`ifdef MUL_EN
  assign w_is_illegal = w_upper || (w_op == OP_BAD);
`else
  assign w_is_illegal = w_upper || (w_op == OP_BAD) || (w_op == OP_MUL);
`endif

  // The limit cycle is the last one in which an ack is still accepted.
  assign w_limit   = (MEM_TIMEOUT != 0) && (r_wait == LIMIT);
  assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEM);

  always_comb begin
    w_alu_op  = 3'b000;
    w_alu_src = 1'b0;
    case (w_op)
      OP_SUB, OP_BEQZ, OP_BNE: w_alu_op = 3'b011;
      OP_XOR:                  w_alu_op = 3'b001;
      OP_AND:                  w_alu_op = 3'b100;
`ifdef MUL_EN
      OP_MUL:                  w_alu_op = 3'b101;
`endif
      OP_MOV, OP_JR:           w_alu_op = 3'b010;
      OP_LDI, OP_READ, OP_STR, OP_JMP, OP_JAL: begin
        w_alu_op  = 3'b010;
        w_alu_src = 1'b1;
      end
      default:                 w_alu_op = 3'b000;
    endcase
  end

  // NOTE: every signal driven from always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (mem.mem_ack)  w_next = S_DECODE;
        else if (w_limit) begin w_next = S_HALT; w_timeout = 1'b1; end
      end
      S_DECODE: begin
        if (w_is_halt)         w_next = S_HALT;
        else if (w_is_illegal) w_next = S_FETCH;
        else                   w_next = S_EXEC;
      end
      S_EXEC: begin
        case (w_op)
          OP_READ, OP_STR:                 w_next = S_MEM;
          OP_JMP, OP_JR, OP_BEQZ, OP_BNE:  w_next = S_FETCH;
          default:                         w_next = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem.mem_ack)  w_next = (w_op == OP_READ) ? S_WB : S_FETCH;
        else if (w_limit) begin w_next = S_HALT; w_timeout = 1'b1; end
      end
      S_WB:    w_next = S_FETCH;
      S_HALT:  if (run) w_next = S_FETCH;
      default: w_next = S_FETCH;
    endcase
  end

  assign w_retire = ((w_next == S_FETCH) &&
                     ((r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB))) ||
                    ((r_state == S_DECODE) && (w_next == S_HALT));

  // NOTE: reset is synchronous; state updates use non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_retired <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_bus_err <= w_timeout;
      if (w_next != r_state)                                   r_wait <= '0;
      else if (w_waiting && !mem.mem_ack && MEM_TIMEOUT != 0)  r_wait <= r_wait + 1'b1;
      if (w_retire) r_retired <= r_retired + 1'b1;
    end
  end

  // Outputs are gated by rst_n so nothing, in particular no write strobe, leaks during reset.
  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_read  = 1'b0;
    mem.mem_write = 1'b0;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    branch    = 1'b0;
    link_sel  = 1'b0;
    reg_write = 1'b0;
    alu_src   = 1'b0;
    alu_op    = 3'b000;
    halted    = 1'b0;
    illegal   = 1'b0;
    bus_err   = 1'b0;
    state     = 3'd0;
    retired   = '0;
    if (rst_n) begin
      state   = r_state;
      retired = r_retired;
      bus_err = r_bus_err;
      case (r_state)
        S_FETCH: begin
          mem.mem_req  = 1'b1;
          mem.mem_read = 1'b1;
        end
        S_DECODE: begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          illegal = w_is_illegal && !w_is_halt;
        end
        S_EXEC: begin
          alu_op  = w_alu_op;
          alu_src = w_alu_src;
          case (w_op)
            OP_JMP, OP_JR: pc_load = 1'b1;
            OP_BEQZ: begin branch = zero;  pc_load = zero;  end
            OP_BNE:  begin branch = ~zero; pc_load = ~zero; end
            default: pc_load = 1'b0;
          endcase
        end
        S_MEM: begin
          alu_op        = w_alu_op;
          alu_src       = w_alu_src;
          mem.mem_req   = 1'b1;
          mem.mem_read  = (w_op == OP_READ);
          mem.mem_write = (w_op == OP_STR);
        end
        S_WB: begin
          alu_op    = w_alu_op;
          alu_src   = w_alu_src;
          reg_write = 1'b1;
          if (w_op == OP_JAL) begin
            link_sel = 1'b1;
            pc_load  = 1'b1;
          end
        end
        S_HALT:  halted = 1'b1;
        default: halted = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (default parameters; honours MUL_EN if defined).
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic       zero, run;
  logic       ir_load, pc_inc, pc_load, branch, link_sel, reg_write, alu_src;
  logic [2:0] alu_op;
  logic       halted, illegal, bus_err;
  logic [2:0] state;
  logic [15:0] retired;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .mem(bus), .opcode(opcode), .zero(zero), .run(run),
    .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .branch(branch),
    .link_sel(link_sel), .reg_write(reg_write), .alu_src(alu_src), .alu_op(alu_op),
    .halted(halted), .illegal(illegal), .bus_err(bus_err), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  logic [12:0] w_flags;
  assign w_flags = {bus.mem_req, bus.mem_read, bus.mem_write, ir_load, pc_inc, pc_load,
                    branch, link_sel, reg_write, alu_src, halted, illegal, bus_err};

  int checks = 0;
  int errors = 0;
  int exp_ret = 0;
  int reqm, reqc, wrc, plc, brc, illc, wrm, lnk;
  logic [3:0] seen_alu;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs n cycles, checking the state each cycle and tallying strobes.
  task automatic run_instr(input string tag, input logic [3:0] op, input logic z,
                           input int n, input logic [23:0] sts, input logic [7:0] ackv);
    reqm = 0; wrc = 0; plc = 0; brc = 0; illc = 0; wrm = 0; lnk = 0; seen_alu = 4'hF;
    for (int k = 0; k < n; k++) begin
      opcode = op; zero = z; bus.mem_ack = ackv[k];
      @(negedge clk);
      check($sformatf("%s_st%0d", tag, k), 32'(state), 32'(sts[3*k +: 3]));
      if (state == 3'd3) reqm += int'(bus.mem_req);
      wrc  += int'(reg_write);
      plc  += int'(pc_load);
      brc  += int'(branch);
      illc += int'(illegal);
      wrm  += int'(bus.mem_write);
      lnk  += int'(link_sel);
      if (state == 3'd2) seen_alu = {alu_src, alu_op};
      tick();
    end
    bus.mem_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; opcode = 4'd0; zero = 1'b0; run = 1'b0; bus.mem_ack = 1'b0;
    tick(); tick();
    check("rst_flags", 32'(w_flags), 0);
    check("rst_state", 32'(state), 0);
    check("rst_ret", 32'(retired), 0);
    rst_n = 1'b1;

    // ADD, zero-wait: 0,1,2,4
    run_instr("add", 4'b0000, 1'b0, 4, 24'({3'd4, 3'd2, 3'd1, 3'd0}), 8'h01);
    exp_ret++;
    check("add_wr", 32'(wrc), 1);
    check("add_alu", 32'(seen_alu), 32'b0000);
    check("add_ret", 32'(retired), 32'(exp_ret));
    check("add_back", 32'(state), 0);

    // READ with MEM ack delayed 3 cycles: 8 cycles total
    run_instr("read", 4'b1010, 1'b0, 8,
              24'({3'd4, 3'd3, 3'd3, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0}), 8'b0100_0001);
    exp_ret++;
    check("read_req", 32'(reqm), 4);
    check("read_wr", 32'(wrc), 1);
    check("read_alu", 32'(seen_alu), 32'b1010);
    check("read_ret", 32'(retired), 32'(exp_ret));

    // BNE with zero=0 takes the branch
    run_instr("bne", 4'b1110, 1'b0, 3, 24'({3'd2, 3'd1, 3'd0}), 8'h01);
    exp_ret++;
    check("bne_pl", 32'(plc), 1);
    check("bne_br", 32'(brc), 1);
    check("bne_alu", 32'(seen_alu), 32'b0011);
    check("bne_back", 32'(state), 0);

    // BEQZ with zero=0 falls through
    run_instr("beqz", 4'b1000, 1'b0, 3, 24'({3'd2, 3'd1, 3'd0}), 8'h01);
    exp_ret++;
    check("beqz_pl", 32'(plc), 0);
    check("beqz_br", 32'(brc), 0);
    check("beqz_ret", 32'(retired), 32'(exp_ret));

    // STR: one write strobe, no register write
    run_instr("str", 4'b1001, 1'b0, 4, 24'({3'd3, 3'd2, 3'd1, 3'd0}), 8'b1001);
    exp_ret++;
    check("str_wrm", 32'(wrm), 1);
    check("str_wr", 32'(wrc), 0);
    check("str_back", 32'(state), 0);

    // JAL: link and PC load in WB
    run_instr("jal", 4'b1100, 1'b0, 4, 24'({3'd4, 3'd2, 3'd1, 3'd0}), 8'h01);
    exp_ret++;
    check("jal_pl", 32'(plc), 1);
    check("jal_lnk", 32'(lnk), 1);
    check("jal_wr", 32'(wrc), 1);
    check("jal_ret", 32'(retired), 32'(exp_ret));

    // Opcode 0101 is illegal
    run_instr("bad", 4'b0101, 1'b0, 2, 24'({3'd1, 3'd0}), 8'h01);
    check("bad_ill", 32'(illc), 1);
    check("bad_wr", 32'(wrc), 0);
    check("bad_ret", 32'(retired), 32'(exp_ret));
    check("bad_back", 32'(state), 0);

`ifdef MUL_EN
    run_instr("mul", 4'b1111, 1'b0, 4, 24'({3'd4, 3'd2, 3'd1, 3'd0}), 8'h01);
    exp_ret++;
    check("mul_alu", 32'(seen_alu), 32'b0101);
    check("mul_wr", 32'(wrc), 1);
    check("mul_ret", 32'(retired), 32'(exp_ret));
`else
    run_instr("mul", 4'b1111, 1'b0, 2, 24'({3'd1, 3'd0}), 8'h01);
    check("mul_ill", 32'(illc), 1);
    check("mul_wr", 32'(wrc), 0);
    check("mul_ret", 32'(retired), 32'(exp_ret));
`endif

    // Fetch timeout: ack stuck low
    reqc = 0; brc = 0;
    opcode = 4'b0000; bus.mem_ack = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      reqc += int'(bus.mem_req);
      if (state != 3'd0) brc++;
      tick();
    end
    @(negedge clk);
    check("to_req_cycles", 32'(reqc), 15);
    check("to_stayed_fetch", 32'(brc), 0);
    check("to_state", 32'(state), 5);
    check("to_buserr", 32'(bus_err), 1);
    check("to_halted", 32'(halted), 1);
    check("to_req_drop", 32'(bus.mem_req), 0);
    tick();
    @(negedge clk);
    check("to_buserr_pulse", 32'(bus_err), 0);
    check("to_halted2", 32'(halted), 1);
    check("to_ret", 32'(retired), 32'(exp_ret));
    tick();
    run = 1'b1;
    tick();
    run = 1'b0;
    check("to_resume", 32'(state), 0);

    // HALT instruction retires and halts
    run_instr("halt", 4'b0111, 1'b0, 3, 24'({3'd5, 3'd1, 3'd0}), 8'h01);
    exp_ret++;
    check("halt_state", 32'(state), 5);
    check("halt_flag", 32'(halted), 1);
    check("halt_ret", 32'(retired), 32'(exp_ret));
    run = 1'b1;
    tick();
    run = 1'b0;
    check("halt_resume", 32'(state), 0);

    // Reset while a READ waits in MEM
    run_instr("rdrst", 4'b1010, 1'b0, 4, 24'({3'd3, 3'd2, 3'd1, 3'd0}), 8'h01);
    check("rdrst_inmem", 32'(state), 3);
    rst_n = 1'b0;
    #1;
    check("rdrst_flags_now", 32'(w_flags), 0);
    check("rdrst_state_now", 32'(state), 0);
    tick();
    check("rdrst_flags", 32'(w_flags), 0);
    check("rdrst_ret", 32'(retired), 0);
    rst_n = 1'b1;
    exp_ret = 0;

    // Fetch ack arriving in the limit cycle wins over the timeout
    reqc = 0;
    opcode = 4'b0000;
    for (int k = 0; k < 15; k++) begin
      bus.mem_ack = (k == 14);
      @(negedge clk);
      reqc += int'(bus.mem_req);
      tick();
    end
    bus.mem_ack = 1'b0;
    check("lim_req", 32'(reqc), 15);
    check("lim_decode", 32'(state), 1);
    check("lim_buserr", 32'(bus_err), 0);
    tick(); tick(); tick();
    exp_ret++;
    check("lim_back", 32'(state), 0);
    check("lim_ret", 32'(retired), 32'(exp_ret));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
